// File: rtl/sprite_blit_engine.sv
// Sprite compositor: walks an SPR_W x SPR_H sprite, substitutes background for key-coloured
// pixels (or everything in erase mode), clips at the screen edge and emits one plot slot per pixel.
// Optional horizontal mirroring is enabled by defining BLIT_HFLIP_EN.

module sprite_blit_engine #(
  parameter int SPR_W    = 12,
  parameter int SPR_H    = 16,
  parameter int SCR_W    = 160,
  parameter int SCR_H    = 120,
  parameter int COLOUR_W = 24,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = 24'hFFFFFF
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             start,
  input  logic                             erase,
`ifdef BLIT_HFLIP_EN
  input  logic                             flip,
`endif
  input  logic [7:0]                       spr_x,
  input  logic [7:0]                       spr_y,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(SPR_W*SPR_H)-1:0]   spr_addr,
  input  logic [COLOUR_W-1:0]              spr_data,
  output logic [$clog2(SCR_W*SCR_H)-1:0]   bg_addr,
  input  logic [COLOUR_W-1:0]              bg_data,
  output logic [7:0]                       x,
  output logic [7:0]                       y,
  output logic [COLOUR_W-1:0]              colour,
  output logic                             plot
);

  localparam int SPR_AW = $clog2(SPR_W*SPR_H);
  localparam int BG_AW  = $clog2(SCR_W*SCR_H);
  localparam int COL_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [7:0]       r_sprX;
  logic [7:0]       r_sprY;
  logic             r_erase;
`ifdef BLIT_HFLIP_EN
  logic             r_flip;
`endif
  logic             r_busy;
  logic             r_done;
  logic             r_valid;
  logic             r_clip;
  logic [7:0]       r_x;
  logic [7:0]       r_y;

  logic             w_accept;
  logic             w_lastPix;
  logic             w_busyNext;
  logic             w_doneNext;
  logic [COL_W-1:0] w_colEff;
  logic [15:0]      w_px;
  logic [15:0]      w_py;
  logic             w_clip;
  logic             w_useBg;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_lastPix = (r_col == COL_W'(SPR_W-1)) && (r_row == ROW_W'(SPR_H-1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_RUN;
      S_RUN:   if (w_lastPix) w_nextState = S_FLUSH;
      S_FLUSH: w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // busy/done are registered, so done lands one cycle after the DONE state with busy already low
  assign w_busyNext = (w_nextState != S_IDLE);
  assign w_doneNext = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busyNext;
      r_done <= w_doneNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sprX  <= '0;
      r_sprY  <= '0;
      r_erase <= 1'b0;
`ifdef BLIT_HFLIP_EN
      r_flip  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_sprX  <= spr_x;
      r_sprY  <= spr_y;
      r_erase <= erase;
`ifdef BLIT_HFLIP_EN
      r_flip  <= flip;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == S_RUN) begin
      if (r_col == COL_W'(SPR_W-1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Mirroring only changes which sprite texel is fetched; screen position stays raster order
`ifdef BLIT_HFLIP_EN
  assign w_colEff = r_flip ? (COL_W'(SPR_W-1) - r_col) : r_col;
`else
  assign w_colEff = r_col;
`endif

  assign spr_addr = SPR_AW'(r_row * SPR_W + w_colEff);

  // Screen coordinates are widened so positions near 255 neither wrap nor slip past the clip test
  assign w_px    = 16'(r_sprX) + 16'(r_col);
  assign w_py    = 16'(r_sprY) + 16'(r_row);
  assign bg_addr = BG_AW'(32'(w_py) * 32'(SCR_W) + 32'(w_px));
  assign w_clip  = (w_px >= 16'(SCR_W)) || (w_py >= 16'(SCR_H));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_clip  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_valid <= (r_state == S_RUN);
      r_clip  <= w_clip;
      r_x     <= w_px[7:0];
      r_y     <= w_py[7:0];
    end
  end

  // ROM data for the staged pixel arrives now, so the colour choice is made combinationally here
  assign w_useBg = r_erase || (spr_data == KEY_COLOUR);
  assign colour  = r_valid ? (w_useBg ? bg_data : spr_data) : '0;
  assign plot    = r_valid && !r_clip;
  assign x       = r_x;
  assign y       = r_y;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Self-checking bench for sprite_blit_engine: table of blit operations checked slot by slot
// against a scoreboard queue, plus hand-written held-start and mid-run reset sequences.

module tb_sprite_blit_engine;

  localparam int SPR_W = 12;
  localparam int SPR_H = 16;
  localparam int NPIX  = SPR_W * SPR_H;
  localparam logic [23:0] KEY = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        erase;
`ifdef BLIT_HFLIP_EN
  logic        flip;
`endif
  logic [7:0]  spr_x;
  logic [7:0]  spr_y;
  logic        busy;
  logic        done;
  logic [7:0]  spr_addr;
  logic [23:0] spr_data;
  logic [14:0] bg_addr;
  logic [23:0] bg_data;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [23:0] colour;
  logic        plot;

  typedef struct {
    logic [7:0] sx;
    logic [7:0] sy;
    logic       er;
    logic       fl;
    int         pat;
    int         expPlots;
  } vec_t;

  typedef struct {
    logic        plot;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] col;
  } slot_t;

  slot_t       sbQ[$];
  logic [23:0] sprRom [0:255];
  int          compareCount = 0;
  int          failCount    = 0;

  sprite_blit_engine dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .erase    (erase),
`ifdef BLIT_HFLIP_EN
    .flip     (flip),
`endif
    .spr_x    (spr_x),
    .spr_y    (spr_y),
    .busy     (busy),
    .done     (done),
    .spr_addr (spr_addr),
    .spr_data (spr_data),
    .bg_addr  (bg_addr),
    .bg_data  (bg_data),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot)
  );

  always #5 clk = ~clk;

  // Background ROM contents are a function of address, with one marked location
  function automatic logic [23:0] bgFunc(input logic [14:0] a);
    if (a == 15'd3210) return 24'h123456;
    return {8'hA5, 1'b0, a};
  endfunction

  // Both ROMs have one cycle of read latency
  always @(posedge clk) begin
    spr_data <= sprRom[spr_addr];
    bg_data  <= bgFunc(bg_addr);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic loadPattern(input int pat);
    for (int i = 0; i < 256; i++) begin
      case (pat)
        0:       sprRom[i] = 24'h00FF00;
        1:       sprRom[i] = (i == 0) ? KEY : {8'h11, 8'(i), 8'h22};
        default: sprRom[i] = (i % 5 == 0) ? KEY : {8'h40, 8'(i * 3), 8'(255 - i)};
      endcase
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"},    busy,     0);
    checkOutput({tag, "_done"},    done,     0);
    checkOutput({tag, "_plot"},    plot,     0);
    checkOutput({tag, "_xy"},      {x, y},   0);
    checkOutput({tag, "_colour"},  colour,   0);
    checkOutput({tag, "_sprAddr"}, spr_addr, 0);
    checkOutput({tag, "_bgAddr"},  bg_addr,  0);
  endtask

  task automatic applyStimulus(input vec_t v);
    slot_t       s;
    int          flipEff;
    int          px, py, row, col;
    int          plots, busyCnt, doneCnt, doneN;
    logic [23:0] sv;
    loadPattern(v.pat);
    flipEff = 0;
`ifdef BLIT_HFLIP_EN
    flipEff = int'(v.fl);
`endif
    sbQ.delete();
    for (int i = 0; i < NPIX; i++) begin
      row    = i / SPR_W;
      col    = i % SPR_W;
      px     = int'(v.sx) + col;
      py     = int'(v.sy) + row;
      sv     = sprRom[row * SPR_W + ((flipEff != 0) ? (SPR_W - 1 - col) : col)];
      s.plot = (px < 160) && (py < 120);
      s.x    = 8'(px);
      s.y    = 8'(py);
      s.col  = (v.er || sv == KEY) ? bgFunc(15'(py * 160 + px)) : sv;
      sbQ.push_back(s);
    end
    @(negedge clk);
    start = 1'b1;
    erase = v.er;
    spr_x = v.sx;
    spr_y = v.sy;
`ifdef BLIT_HFLIP_EN
    flip  = v.fl;
`endif
    @(posedge clk);
    #1 start = 1'b0;
    plots = 0; busyCnt = 0; doneCnt = 0; doneN = 0;
    for (int n = 1; n <= NPIX + 4; n++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        doneN = n;
      end
      if (plot) plots++;
      if (n == 1) begin
        checkOutput("sprAddrFirst", spr_addr, (flipEff != 0) ? 11 : 0);
        if (v.sx < 160 && v.sy < 120)
          checkOutput("bgAddrFirst", bg_addr, int'(v.sy) * 160 + int'(v.sx));
      end
      if (n == 24) checkOutput("sprAddrPix23", spr_addr, (flipEff != 0) ? 12 : 23);
      if (n >= 2 && n <= NPIX + 1) begin
        s = sbQ.pop_front();
        if (s.plot) checkOutput("plotSlot", {plot, x, y, colour}, {1'b1, s.x, s.y, s.col});
        else        checkOutput("clipSlot", plot, 0);
      end else begin
        checkOutput("noPlotOutsideRun", plot, 0);
      end
    end
    checkOutput("busyCycles", busyCnt, NPIX + 2);
    checkOutput("donePulses", doneCnt, 1);
    checkOutput("doneCycle",  doneN,   NPIX + 3);
    checkOutput("plotCount",  plots,   v.expPlots);
    checkOutput("queueEmpty", sbQ.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    logic gotDone;
    vecs[0] = '{sx: 8'd10,  sy: 8'd20,  er: 1'b0, fl: 1'b0, pat: 0, expPlots: 192};
    vecs[1] = '{sx: 8'd10,  sy: 8'd20,  er: 1'b0, fl: 1'b0, pat: 1, expPlots: 192};
    vecs[2] = '{sx: 8'd0,   sy: 8'd0,   er: 1'b1, fl: 1'b0, pat: 2, expPlots: 192};
    vecs[3] = '{sx: 8'd155, sy: 8'd110, er: 1'b0, fl: 1'b0, pat: 2, expPlots: 50};
    vecs[4] = '{sx: 8'd148, sy: 8'd104, er: 1'b0, fl: 1'b0, pat: 2, expPlots: 192};
    vecs[5] = '{sx: 8'd149, sy: 8'd105, er: 1'b0, fl: 1'b0, pat: 1, expPlots: 165};
    vecs[6] = '{sx: 8'd200, sy: 8'd50,  er: 1'b0, fl: 1'b0, pat: 2, expPlots: 0};
    vecs[7] = '{sx: 8'd30,  sy: 8'd40,  er: 1'b0, fl: 1'b1, pat: 2, expPlots: 192};

    resetn = 1'b0;
    start  = 1'b0;
    erase  = 1'b0;
    spr_x  = '0;
    spr_y  = '0;
`ifdef BLIT_HFLIP_EN
    flip   = 1'b0;
`endif
    loadPattern(0);
    repeat (3) @(negedge clk);
    checkResetState("reset");
    resetn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      $display("[TB] vector %0d: pos (%0d,%0d) erase %0b", v, vecs[v].sx, vecs[v].sy, vecs[v].er);
      applyStimulus(vecs[v]);
    end

    // start held high through a whole run: ignored mid-run, re-accepted after one idle cycle
    $display("[TB] held-start sequence");
    loadPattern(0);
    @(negedge clk);
    start = 1'b1;
    erase = 1'b0;
    spr_x = 8'd10;
    spr_y = 8'd20;
    @(posedge clk);
    for (int n = 1; n <= NPIX + 4; n++) begin
      @(negedge clk);
      if (n == NPIX + 2) checkOutput("heldBusyBeforeDone", busy, 1);
      if (n == NPIX + 3) begin
        checkOutput("heldDone", done, 1);
        checkOutput("heldBusyIdle", busy, 0);
      end
      if (n == NPIX + 4) checkOutput("heldRestart", busy, 1);
    end
    start = 1'b0;
    gotDone = 1'b0;
    for (int n = 0; n < 300 && !gotDone; n++) begin
      @(negedge clk);
      if (done) gotDone = 1'b1;
    end
    checkOutput("heldSecondDone", gotDone, 1);

    // reset asserted mid-run after pixel 50's plot slot
    $display("[TB] mid-run reset sequence");
    @(negedge clk);
    start = 1'b1;
    spr_x = 8'd10;
    spr_y = 8'd20;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 52; n++) @(negedge clk);
    checkOutput("midRunPlot", {plot, x, y}, {1'b1, 8'd12, 8'd24});
    resetn = 1'b0;
    @(negedge clk);
    checkResetState("midReset");
    @(negedge clk);
    checkOutput("midResetHold", {busy, plot}, 0);
    resetn = 1'b1;
    @(negedge clk);
    applyStimulus(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
